noc_traffic_gen: RTL

//  Synthesizable per-node traffic generator/sink for OpenNoC evaluation; one instance per PE, X*Y tiled.

---
 rtl/noc_traffic_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_gen.sv
// Per-node NoC traffic generator and sink: injects timestamped packets toward a
// pattern-selected destination and accumulates receive count and latency statistics.
module noc_traffic_gen #(
  parameter int          X          = 10,
  parameter int          Y          = 10,
  parameter int          x_size     = 4,
  parameter int          y_size     = 4,
  parameter int          data_width = 256,
  parameter int          MY_X       = 0,
  parameter int          MY_Y       = 0,
  parameter int          HOT_X      = 0,
  parameter int          HOT_Y      = 0,
  parameter logic [31:0] SEED       = 32'hACE1_0001
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [7:0]                          rate,
  input  logic [1:0]                          pattern_sel,
  input  logic [31:0]                         num_packets,
  output logic                                tx_valid,
  output logic [x_size+y_size+data_width-1:0] tx_data,
  input  logic                                tx_ready,
  input  logic                                rx_valid,
  input  logic [x_size+y_size+data_width-1:0] rx_data,
  output logic [31:0]                         sent_count,
  output logic [31:0]                         recv_count,
  output logic [31:0]                         misroute,
  output logic [47:0]                         lat_sum,
  output logic [31:0]                         lat_max,
  output logic                                busy,
  output logic                                done
);

  localparam int          HDR_W     = x_size + y_size;
  localparam int          PKT_W     = HDR_W + data_width;
  localparam logic [31:0] SEED_MIX  = SEED ^ 32'(MY_Y * X + MY_X);
  localparam logic [31:0] SEED_EFF  = (SEED_MIX == 32'd0) ? 32'd1 : SEED_MIX;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;  // x^32+x^22+x^2+x+1, right-shift form

  localparam int TR_X = MY_Y % X;
  localparam int TR_Y = MY_X % Y;
  localparam int BC_X = X - 1 - MY_X;
  localparam int BC_Y = Y - 1 - MY_Y;
  localparam bit TR_SELF  = (TR_X == MY_X) && (TR_Y == MY_Y);
  localparam bit BC_SELF  = (BC_X == MY_X) && (BC_Y == MY_Y);
  localparam bit HOT_SELF = (HOT_X == MY_X) && (HOT_Y == MY_Y);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [31:0]           cyc;
  logic [31:0]           lfsr, lfsr_next;
  logic [7:0]            timer;
  logic                  hs, slot_free, timer_hit, build;
  logic [31:0]           sent_inc;
  logic [x_size-1:0]     rnd_x, dst_x;
  logic [y_size-1:0]     rnd_y, dst_y;
  logic [data_width-1:0] payload;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rnd_x = x_size'(lfsr[15:0] % 16'(X));
    rnd_y = y_size'(lfsr[31:16] % 16'(Y));
    if (rnd_x == x_size'(MY_X) && rnd_y == y_size'(MY_Y))
      rnd_x = x_size'((16'(rnd_x) + 16'd1) % 16'(X));
    dst_x = rnd_x;
    dst_y = rnd_y;
    case (pattern_sel)
      2'd1: if (!TR_SELF) begin
        dst_x = x_size'(TR_X);
        dst_y = y_size'(TR_Y);
      end
      2'd2: if (!BC_SELF) begin
        dst_x = x_size'(BC_X);
        dst_y = y_size'(BC_Y);
      end
      2'd3: if (!HOT_SELF) begin
        dst_x = x_size'(HOT_X);
        dst_y = y_size'(HOT_Y);
      end
      default: ;
    endcase
  end

  // A handshake in the same cycle frees the slot, so the sequence number of a
  // packet built then must already include the one being accepted.
  always_comb begin
    hs        = tx_valid && tx_ready;
    sent_inc  = sent_count + {31'd0, hs};
    slot_free = !tx_valid || hs;
    timer_hit = (timer <= 8'd1) || (rate <= 8'd1);
    build     = (state == S_RUN) && start && slot_free && timer_hit && (sent_inc < num_packets);
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);

    payload = '0;
    for (int i = 64; i < data_width; i++) payload[i] = lfsr[i % 32];
    payload[31:0]  = cyc;
    payload[63:32] = sent_inc;

    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (num_packets == 32'd0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (slot_free && sent_inc >= num_packets) state_nxt = S_DONE;
        else if (slot_free && !start)             state_nxt = S_IDLE;
      end
      S_DONE: if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc        <= 32'd0;
      lfsr       <= SEED_EFF;
      timer      <= 8'd0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      sent_count <= 32'd0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc + 32'd1;
      if (state == S_IDLE && start) begin
        sent_count <= 32'd0;
        timer      <= rate;
      end
      if (hs) sent_count <= sent_inc;
      if (build) begin
        tx_valid <= 1'b1;
        tx_data  <= {payload, dst_y, dst_x};
        lfsr     <= lfsr_next;
        timer    <= rate;
      end else begin
        if (hs) tx_valid <= 1'b0;
        // Timer stalls while a packet is blocked by the NoC.
        if (state == S_RUN && slot_free && timer != 8'd0) timer <= timer - 8'd1;
      end
    end
  end

  logic [x_size-1:0] rx_dx;
  logic [y_size-1:0] rx_dy;
  logic [31:0]       rx_lat;
  logic [48:0]       lat_acc;
  logic              unused_rx;

  always_comb begin
    rx_dx     = rx_data[x_size-1:0];
    rx_dy     = rx_data[x_size +: y_size];
    rx_lat    = cyc - rx_data[HDR_W +: 32];
    lat_acc   = {1'b0, lat_sum} + {17'd0, rx_lat};
    unused_rx = ^rx_data[PKT_W-1:HDR_W+32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      recv_count <= 32'd0;
      misroute   <= 32'd0;
      lat_sum    <= 48'd0;
      lat_max    <= 32'd0;
    end else if (rx_valid) begin
      recv_count <= recv_count + 32'd1;
      lat_sum    <= lat_acc[48] ? {48{1'b1}} : lat_acc[47:0];
      if (rx_lat > lat_max) lat_max <= rx_lat;
      if (rx_dx != x_size'(MY_X) || rx_dy != y_size'(MY_Y)) misroute <= misroute + 32'd1;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
